param_scan_decoder: RTL and testbench
=====================================

# param_scan_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable, the generalised successor to the fixed-width combinational decoders in the basic-elements library. Adds a scan mode: an internal prescaler and index counter sweep the active output through 0..last at a programmable rate. Intended for digit/row select on multiplexed displays and for chip-select fan-out where the select must be glitch-free.

## Interface
Parameters:
- SEL_W, 3, select width; output width is 2**SEL_W (derived, not a parameter)
- DIV_W, 16, prescaler width
- ACTIVE_LOW, 0, 1 inverts every bit of out (inactive = all ones)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  1 = decoder active; 0 = out forced inactive
- mode  input  1  0 = DIRECT, 1 = SCAN
- load  input  1  single-cycle strobe: idx <= sel
- sel  input  SEL_W  index to load
- last  input  SEL_W  highest scan index (inclusive)
- div  input  DIV_W  scan advances every div+1 cycles
- out  output  2**SEL_W  registered one-hot (or one-cold) select
- idx  output  SEL_W  current index
- tick  output  1  one-cycle pulse on each scan advance
- wrap  output  1  one-cycle pulse when scan returns to 0

## Operation
- Reset is synchronous, active-high. Effects: out = inactive (all 0, or all 1 if ACTIVE_LOW); idx = 0; tick = 0; wrap = 0; prescaler = 0; state = IDLE.
- States are IDLE, DIRECT and SCAN, evaluated each cycle.
  - IDLE when en = 0.
  - DIRECT when en = 1 and mode = 0.
  - SCAN when en = 1 and mode = 1.
- IDLE:
  - out is inactive. Prescaler is held at 0. tick = wrap = 0.
  - idx is retained. load still updates idx.
- DIRECT:
  - On load, idx <= sel.
  - out = decode(next idx).
  - Prescaler is held at 0. tick and wrap are never asserted.
- SCAN:
  - Prescaler counts 0..div. When it equals div, it returns to 0 and tick = 1.
  - On tick, the index steps: if idx >= last then idx <= 0 and wrap = 1, else idx <= idx + 1.
  - div = 0 advances idx every cycle.
  - last = 0 holds idx at 0 and pulses wrap on every tick.
- load in SCAN:
  - load has priority over advance: idx <= sel and prescaler <= 0.
  - No tick or wrap in the load cycle.
  - If sel > last, the next advance wraps to 0.
- A change of mode or en clears the prescaler in that cycle. idx is retained across the change.
- Decode: out bit k is active exactly when idx_next == k. Exactly one bit is active whenever en = 1; none is active when en = 0.
- div and last are sampled every cycle. Changing them mid-scan takes effect at the next comparison, with no reset of idx.
  - If div is lowered below the current prescaler value, the prescaler keeps counting, wraps at 2^DIV_W, then matches.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- Latency is 1 cycle:
  - load/sel at edge t gives idx and out at edge t+1.
  - en falling at edge t gives out inactive at t+1.
  - en rising at t gives out = decode(idx) at t+1.
- tick and wrap are high for exactly one cycle and aligned with the idx/out update they cause.
- Scan period per index is div+1 cycles. A full sweep takes (last+1)*(div+1) cycles.
- Reset mid-scan: outputs take their reset values on the next edge. The scan restarts from idx 0 with the prescaler at 0 once rst is released.

## Test plan
- Reset with SEL_W=3, rst held 2 cycles: out=8'h00, idx=0, tick=0, wrap=0. With ACTIVE_LOW=1, out=8'hFF.
- DIRECT sweep, en=1, mode=0: load sel=0..7, one per cycle. out = 8'h01, 02, 04, … 80, each one cycle after its load. tick=0 throughout.
- en toggling: with idx=5, drop en for 3 cycles then raise it. out is 8'h00 one cycle after the fall and 8'h20 one cycle after the rise. idx stays 5.
- SCAN with div=2, last=5 from idx 0: idx goes 0,1,2,3,4,5,0 and changes every 3 cycles. tick pulses on each change. wrap pulses only on the 5->0 step.
- load mid-scan: in SCAN with div=3 at idx 2 and prescaler 1, assert load with sel=7 and last=5. idx=7 next cycle with no tick. Four cycles later idx=0 and wrap=1.
- rst asserted mid-scan at idx 4 with div=0: on the next edge all outputs take their reset values. After release, idx goes 0,1,2,… every cycle.

Source files
------------

// File: rtl/param_scan_decoder_if.sv
// Handshake/bus bundle for param_scan_decoder.
// master drives the controls and select values; slave returns the registered outputs.
interface param_scan_decoder_if #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 16
);
    localparam int N = 1 << SEL_W;

    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] last;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     out;
    logic [SEL_W-1:0] idx;
    logic             tick;
    logic             wrap;

    modport master (
        output en, mode, load, sel, last, div,
        input  out, idx, tick, wrap
    );

    modport slave (
        input  en, mode, load, sel, last, div,
        output out, idx, tick, wrap
    );
endinterface

// File: rtl/param_scan_decoder.sv
// Registered one-hot decoder with enable and a prescaled scan mode.
// Every output is registered, so the select lines cannot glitch.
module param_scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic                clk,
    input logic                rst,
    param_scan_decoder_if.slave bus
);
    localparam int N = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [DIV_W-1:0] psc_q;
    logic [DIV_W-1:0] psc_n;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_n;
    logic [N-1:0]     out_q;
    logic [N-1:0]     out_n;
    logic [N-1:0]     dec;
    logic             tick_q;
    logic             tick_n;
    logic             wrap_q;
    logic             wrap_n;
    logic             chg;

    always_comb begin
        state_n = IDLE;
        unique case (1'b1)
            !bus.en:              state_n = IDLE;
            bus.en && !bus.mode:  state_n = DIRECT;
            bus.en && bus.mode:   state_n = SCAN;
            default:              state_n = IDLE;
        endcase
    end

    assign chg = (state_n != state_q);

    // A state change or a load restarts the prescaler from 0 without advancing.
    always_comb begin
        psc_n  = '0;
        tick_n = 1'b0;
        if (state_n == SCAN && !chg && !bus.load) begin
            if (psc_q == bus.div) begin
                psc_n  = '0;
                tick_n = 1'b1;
            end else begin
                psc_n = psc_q + 1'b1;
            end
        end
    end

    always_comb begin
        idx_n  = idx_q;
        wrap_n = 1'b0;
        if (bus.load) begin
            idx_n = bus.sel;
        end else if (tick_n) begin
            if (idx_q >= bus.last) begin
                idx_n  = '0;
                wrap_n = 1'b1;
            end else begin
                idx_n = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        dec   = {{(N-1){1'b0}}, 1'b1} << idx_n;
        out_n = (state_n == IDLE) ? '0 : dec;
        if (ACTIVE_LOW)
            out_n = ~out_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            psc_q   <= '0;
            idx_q   <= '0;
            out_q   <= ACTIVE_LOW ? '1 : '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            psc_q   <= psc_n;
            idx_q   <= idx_n;
            out_q   <= out_n;
            tick_q  <= tick_n;
            wrap_q  <= wrap_n;
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.tick = tick_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_param_scan_decoder.sv
// Directed bench for param_scan_decoder (SEL_W=3) with an active-low twin.
// Inputs change 1ns after a rising edge; outputs are checked 1ns after the next.
module tb_param_scan_decoder;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    param_scan_decoder_if #(.SEL_W(3), .DIV_W(16)) bus ();
    param_scan_decoder_if #(.SEL_W(3), .DIV_W(16)) bus_l ();

    assign bus_l.en   = bus.en;
    assign bus_l.mode = bus.mode;
    assign bus_l.load = bus.load;
    assign bus_l.sel  = bus.sel;
    assign bus_l.last = bus.last;
    assign bus_l.div  = bus.div;

    param_scan_decoder #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    param_scan_decoder #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1'b1)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.mode = 1'b0;
        bus.load = 1'b0;
        bus.sel  = 3'd0;
        bus.last = 3'd0;
        bus.div  = 16'd0;
        cyc(2);
        chk("rst_out", 32'(bus.out), 32'h00);
        chk("rst_idx", 32'(bus.idx), 32'd0);
        chk("rst_tick", 32'(bus.tick), 32'd0);
        chk("rst_wrap", 32'(bus.wrap), 32'd0);
        chk("rst_out_al", 32'(bus_l.out), 32'hFF);
        rst = 1'b0;

        // DIRECT sweep: one load per cycle
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.load = 1'b1;
            bus.sel  = 3'(i);
            cyc(1);
            chk("dir_out", 32'(bus.out), 32'h1 << i);
            chk("dir_idx", 32'(bus.idx), 32'(i));
            chk("dir_tick", 32'(bus.tick), 32'd0);
            if (i == 3)
                chk("dir_out_al", 32'(bus_l.out), 32'hF7);
        end

        // en toggling at idx 5
        bus.sel = 3'd5;
        cyc(1);
        bus.load = 1'b0;
        bus.en   = 1'b0;
        cyc(1);
        chk("en_fall_out", 32'(bus.out), 32'h00);
        chk("en_fall_out_al", 32'(bus_l.out), 32'hFF);
        chk("en_fall_idx", 32'(bus.idx), 32'd5);
        cyc(2);
        chk("en_low_out", 32'(bus.out), 32'h00);
        bus.en = 1'b1;
        cyc(1);
        chk("en_rise_out", 32'(bus.out), 32'h20);
        chk("en_rise_idx", 32'(bus.idx), 32'd5);

        // SCAN div=2 last=5 from idx 0
        bus.load = 1'b1;
        bus.sel  = 3'd0;
        cyc(1);
        bus.load = 1'b0;
        bus.mode = 1'b1;
        bus.div  = 16'd2;
        bus.last = 3'd5;
        cyc(1);
        chk("scan_entry_idx", 32'(bus.idx), 32'd0);
        chk("scan_entry_tick", 32'(bus.tick), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            cyc(2);
            chk("scan_hold_idx", 32'(bus.idx), 32'((k - 1) % 6));
            chk("scan_hold_tick", 32'(bus.tick), 32'd0);
            cyc(1);
            chk("scan_step_idx", 32'(bus.idx), 32'(k % 6));
            chk("scan_step_out", 32'(bus.out), 32'h1 << (k % 6));
            chk("scan_step_tick", 32'(bus.tick), 32'd1);
            chk("scan_step_wrap", 32'(bus.wrap), (k == 6) ? 32'd1 : 32'd0);
        end

        // load mid-scan: idx 2, prescaler 1, div 3
        bus.div  = 16'd3;
        bus.load = 1'b1;
        bus.sel  = 3'd2;
        cyc(1);
        bus.load = 1'b0;
        cyc(1);
        chk("ld_pre_idx", 32'(bus.idx), 32'd2);
        bus.load = 1'b1;
        bus.sel  = 3'd7;
        bus.last = 3'd5;
        cyc(1);
        chk("ld_idx", 32'(bus.idx), 32'd7);
        chk("ld_out", 32'(bus.out), 32'h80);
        chk("ld_tick", 32'(bus.tick), 32'd0);
        chk("ld_wrap", 32'(bus.wrap), 32'd0);
        bus.load = 1'b0;
        cyc(3);
        chk("ld_hold_idx", 32'(bus.idx), 32'd7);
        chk("ld_hold_tick", 32'(bus.tick), 32'd0);
        cyc(1);
        chk("ld_wrap_idx", 32'(bus.idx), 32'd0);
        chk("ld_wrap_out", 32'(bus.out), 32'h01);
        chk("ld_wrap_wrap", 32'(bus.wrap), 32'd1);

        // reset mid-scan at idx 4, div 0
        bus.div  = 16'd0;
        bus.load = 1'b1;
        bus.sel  = 3'd4;
        cyc(1);
        bus.load = 1'b0;
        chk("pre_rst_idx", 32'(bus.idx), 32'd4);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_out", 32'(bus.out), 32'h00);
        chk("mid_rst_idx", 32'(bus.idx), 32'd0);
        chk("mid_rst_tick", 32'(bus.tick), 32'd0);
        chk("mid_rst_out_al", 32'(bus_l.out), 32'hFF);
        rst = 1'b0;
        cyc(1);
        chk("rel_idx", 32'(bus.idx), 32'd0);
        chk("rel_out", 32'(bus.out), 32'h01);
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            chk("rel_step_idx", 32'(bus.idx), 32'(k));
            chk("rel_step_tick", 32'(bus.tick), 32'd1);
        end

        // last = 0: wrap on every tick, idx pinned at 0
        bus.last = 3'd0;
        for (int k = 0; k < 2; k++) begin
            cyc(1);
            chk("last0_idx", 32'(bus.idx), 32'd0);
            chk("last0_wrap", 32'(bus.wrap), 32'd1);
        end

        // en drop during SCAN
        bus.en = 1'b0;
        cyc(1);
        chk("scan_off_out", 32'(bus.out), 32'h00);
        chk("scan_off_tick", 32'(bus.tick), 32'd0);
        chk("scan_off_wrap", 32'(bus.wrap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
